// File: rtl/mpsoc_ahb3_pkg.sv
// -----------------------------------------------------------------------------
// mpsoc_ahb3_pkg
// Shared AHB3-Lite types for the external-port responder:
//   htrans_t     - transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_t      - transfer size encoding (byte .. 1024-bit)
//   HRESP_*      - response encodings
//   resp_state_t - data-phase state of the responder
//   trans_active - true for transfer types that start a data phase
// -----------------------------------------------------------------------------
package mpsoc_ahb3_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_128   = 3'd4,
    HSIZE_256   = 3'd5,
    HSIZE_512   = 3'd6,
    HSIZE_1024  = 3'd7
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } resp_state_t;

  function automatic logic trans_active(input htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/mpsoc_ahb3_bytemask.sv
// -----------------------------------------------------------------------------
// mpsoc_ahb3_bytemask
// Combinational byte-lane decoder: (address low bits, transfer size) -> one
// enable bit per byte lane of the XLEN data bus. Sizes at or above the bus
// width enable every lane; misaligned low bits are ignored, so the enabled
// lanes are always the size-aligned block that contains the address.
// Ports:
//   addr_lo  in   log2(XLEN/8)  byte offset within the bus word
//   size     in   hsize_t       transfer size
//   byte_en  out  XLEN/8        byte-lane enables
// -----------------------------------------------------------------------------
module mpsoc_ahb3_bytemask
  import mpsoc_ahb3_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int LB  = $clog2(NB)
) (
  input  logic [LB-1:0] addr_lo,
  input  hsize_t        size,
  output logic [NB-1:0] byte_en
);

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_en = '0;
    for (int i = 0; i < NB; i++) begin
      if (int'(size) >= LB) byte_en[i] = 1'b1;
      else byte_en[i] = ((i >> int'(size)) == (int'(addr_lo) >> int'(size)));
    end
  end

endmodule

// File: rtl/mpsoc_ahb3_ext_responder.sv
// -----------------------------------------------------------------------------
// mpsoc_ahb3_ext_responder
// AHB3-Lite slave at the far end of a tile's external AHB port. Word-organised
// local memory, registered address phase, WAIT_STATES extra data-phase cycles
// per OKAY transfer, byte/half/word lanes, two-cycle ERROR response.
//
// Build option: define MPSOC_AHB3_EXT_ERR_EN to answer out-of-range,
// misaligned and wider-than-bus transfers with ERROR. Without it, addresses
// wrap modulo DEPTH, low bits are forced to alignment and hresp_o is OKAY.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ahb3_hsel_i           slave select
//   ahb3_haddr_i  [PLEN]  byte address (address phase)
//   ahb3_hwdata_i [XLEN]  write data (data phase)
//   ahb3_hwrite_i         1 = write
//   ahb3_hsize_i  [3]     transfer size
//   ahb3_hburst_i [3]     unused, every beat decoded on its own
//   ahb3_hprot_i  [4]     unused
//   ahb3_htrans_i [2]     transfer type
//   ahb3_hmastlock_i      unused
//   ahb3_hrdata_o [XLEN]  read data, valid in the completing cycle of a read
//   ahb3_hready_o         transfer done / slave ready
//   ahb3_hresp_o          0 = OKAY, 1 = ERROR
// -----------------------------------------------------------------------------
module mpsoc_ahb3_ext_responder
  import mpsoc_ahb3_pkg::*;
#(
  parameter int              PLEN        = 32,
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 1024,
  parameter logic [PLEN-1:0] BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ahb3_hsel_i,
  input  logic [PLEN-1:0] ahb3_haddr_i,
  input  logic [XLEN-1:0] ahb3_hwdata_i,
  input  logic            ahb3_hwrite_i,
  input  logic [2:0]      ahb3_hsize_i,
  input  logic [2:0]      ahb3_hburst_i,
  input  logic [3:0]      ahb3_hprot_i,
  input  logic [1:0]      ahb3_htrans_i,
  input  logic            ahb3_hmastlock_i,
  output logic [XLEN-1:0] ahb3_hrdata_o,
  output logic            ahb3_hready_o,
  output logic            ahb3_hresp_o
);

  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  htrans_t         trans;
  hsize_t          size_in;
  logic            accept;
  logic            addr_err;
  logic [PLEN-1:0] offset;

  resp_state_t     state, next_state;
  logic [3:0]      wait_cnt;
  logic [AW-1:0]   dp_word;
  logic [LB-1:0]   dp_lo;
  hsize_t          dp_size;
  logic            dp_write;
  logic [NB-1:0]   byte_en;

  logic [XLEN-1:0] mem [DEPTH];

  assign trans   = htrans_t'(ahb3_htrans_i);
  assign size_in = hsize_t'(ahb3_hsize_i);
  assign accept  = ahb3_hsel_i & ahb3_hready_o & trans_active(trans);
  assign offset  = ahb3_haddr_i - BASE_ADDR;

  // Burst/protection/lock carry no meaning here; the upper offset bits only
  // matter for the range check.
  logic unused_inputs;
  assign unused_inputs = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i, offset};

`ifdef MPSOC_AHB3_EXT_ERR_EN
  localparam logic [PLEN:0] MEM_BYTES = (PLEN+1)'(DEPTH * NB);
  logic out_of_range, misaligned, too_wide;

  assign out_of_range = (ahb3_haddr_i < BASE_ADDR) || ({1'b0, offset} >= MEM_BYTES);
  assign too_wide     = int'(size_in) > LB;

  always_comb begin
    misaligned = 1'b0;
    for (int b = 0; b < LB; b++)
      if ((b < int'(size_in)) && ahb3_haddr_i[b]) misaligned = 1'b1;
  end

  assign addr_err = out_of_range | misaligned | too_wide;
`else
  assign addr_err = 1'b0;
`endif

  // State register plus the registered address phase.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      dp_word  <= '0;
      dp_lo    <= '0;
      dp_size  <= HSIZE_BYTE;
      dp_write <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        wait_cnt <= WAIT_LOAD;
        dp_word  <= offset[LB +: AW];
        dp_lo    <= ahb3_haddr_i[LB-1:0];
        dp_size  <= size_in;
        dp_write <= ahb3_hwrite_i;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Next state. Every hready_o=1 state can take a new accept, which is what
  // lets S_DONE chain straight into the next transfer.
  always_comb begin
    next_state = state;
    case (state)
      S_WAIT: if (wait_cnt == 4'd1) next_state = S_DONE;
`ifdef MPSOC_AHB3_EXT_ERR_EN
      S_ERR1: next_state = S_ERR2;
`endif
      default: begin
        if (!accept)              next_state = S_IDLE;
        else if (addr_err)        next_state = S_ERR1;
        else if (WAIT_STATES == 0) next_state = S_DONE;
        else                      next_state = S_WAIT;
      end
    endcase
  end

  // Outputs depend on state only, so hready_o never loops back through accept.
  always_comb begin
    ahb3_hready_o = 1'b1;
    ahb3_hresp_o  = HRESP_OKAY;
    ahb3_hrdata_o = '0;
    case (state)
      S_WAIT: ahb3_hready_o = 1'b0;
      S_DONE: ahb3_hrdata_o = mem[dp_word];
`ifdef MPSOC_AHB3_EXT_ERR_EN
      S_ERR1: begin
        ahb3_hready_o = 1'b0;
        ahb3_hresp_o  = HRESP_ERROR;
      end
      S_ERR2: ahb3_hresp_o = HRESP_ERROR;
`endif
      default: ;
    endcase
  end

  mpsoc_ahb3_bytemask #(.XLEN(XLEN)) u_bytemask (
    .addr_lo (dp_lo),
    .size    (dp_size),
    .byte_en (byte_en)
  );

  // Write lands on the completing edge, so a read chained behind it already
  // sees the new word in its own data phase.
  // NOTE: the memory array has no reset; clearing it would turn the RAM into
  // flops and its contents are defined by software, not by reset.
  always_ff @(posedge clk) begin
    if ((state == S_DONE) && dp_write) begin
      for (int b = 0; b < NB; b++)
        if (byte_en[b]) mem[dp_word][8*b +: 8] <= ahb3_hwdata_i[8*b +: 8];
    end
  end

endmodule
